// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: bus widths,
// funct codes, FSM state encoding and small arithmetic helpers.
package muldiv_ctrl_pkg;

  localparam int DATA_W            = 32;
  localparam int FUNCT_W           = 6;
  localparam int DIV_ITERS_DEFAULT = 32;

  localparam logic [FUNCT_W-1:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [FUNCT_W-1:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [FUNCT_W-1:0] FUNCT_MULT  = 6'b011000;
  localparam logic [FUNCT_W-1:0] FUNCT_MULTU = 6'b011001;
  localparam logic [FUNCT_W-1:0] FUNCT_DIV   = 6'b011010;
  localparam logic [FUNCT_W-1:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    MDU_IDLE   = 2'd0,
    MDU_MUL    = 2'd1,
    MDU_DIV    = 2'd2,
    MDU_DIVFIX = 2'd3
  } mdu_state_t;

  // Magnitude of a two's complement word; the most negative value maps to
  // itself, which is its correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs_w(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 1'b1) : v;
  endfunction

  // Conditional two's complement negation used by the divide sign fix-up.
  function automatic logic [DATA_W-1:0] neg_if(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_div_radix2.sv
// Iterative restoring radix-2 unsigned divider. 'start' loads the operands,
// each cycle with 'step' high performs one shift-subtract, and 'done' is
// high during the cycle whose step produces the final quotient/remainder.
module div_radix2
  import muldiv_ctrl_pkg::*;
#(
  parameter int ITERS = DIV_ITERS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              done
);

  // acc holds {remainder, quotient}; quotient bits shift in from the right
  logic [2*DATA_W-1:0] acc;
  logic [DATA_W-1:0]   divisor_q;
  logic [5:0]          count;

  logic [DATA_W:0]     shifted;
  logic [DATA_W-1:0]   diff;
  logic                fits;

  // One restoring step: the partial remainder needs DATA_W+1 bits after the
  // shift, so the compare is done at full width; the difference always fits
  // back into DATA_W bits because it is smaller than the divisor.
  always_comb begin
    shifted = {acc[2*DATA_W-1:DATA_W], acc[DATA_W-1]};
    fits    = (shifted >= {1'b0, divisor_q});
    diff    = shifted[DATA_W-1:0] - divisor_q;
  end

  // Datapath registers: load on start, iterate on step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      divisor_q <= '0;
      count     <= '0;
    end else if (start) begin
      acc       <= {{DATA_W{1'b0}}, dividend};
      divisor_q <= divisor;
      count     <= '0;
    end else if (step) begin
      acc       <= {(fits ? diff : shifted[DATA_W-1:0]), acc[DATA_W-2:0], fits};
      count     <= count + 6'd1;
    end
  end

  assign quotient  = acc[DATA_W-1:0];
  assign remainder = acc[2*DATA_W-1:DATA_W];
  assign done      = step && (count == 6'(ITERS - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage HI/LO sequencer: MULT/MULTU through an external combinational
// multiplier, DIV/DIVU through the iterative divider, MTHI/MTLO directly.
// Owns HI/LO and raises stall_req while an operation must hold the pipe.
//
// Handshake: op_valid is a level held by EX for as long as stall_req is
// high; an operation is taken only in IDLE with op_valid=1 and flush=0,
// and a still-asserted op_valid outside IDLE is not a new request.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DIV_ITERS = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [DATA_W-1:0]   operand_1,
  input  logic [DATA_W-1:0]   operand_2,
  input  logic                flush,
  output logic                mul_en,
  output logic [FUNCT_W-1:0]  mul_funct,
  output logic [DATA_W-1:0]   mul_op1,
  output logic [DATA_W-1:0]   mul_op2,
  input  logic [2*DATA_W-1:0] mul_result,
  output logic                stall_req,
  output logic                busy,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo,
  output logic [1:0]          fsm_state
);

  mdu_state_t state, state_nxt;

  logic              is_mul, is_div, is_signed_div, is_mthi, is_mtlo;
  logic              div_by_zero, accept;
  logic              div_start, div_step, div_done;
  logic              wr_mul, wr_div;
  logic [DATA_W-1:0] div_dividend, div_divisor;
  logic [DATA_W-1:0] div_quot, div_rem;
  logic              q_neg, r_neg, zero_q;

  // Instruction decode and the accept condition
  always_comb begin
    is_mul        = (funct == FUNCT_MULT) || (funct == FUNCT_MULTU);
    is_div        = (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
    is_signed_div = (funct == FUNCT_DIV);
    is_mthi       = (funct == FUNCT_MTHI);
    is_mtlo       = (funct == FUNCT_MTLO);
    div_by_zero   = (operand_2 == '0);
    accept        = (state == MDU_IDLE) && op_valid && !flush;
    // Divide-by-zero loads the raw dividend so it can be returned in HI
    div_dividend  = (is_signed_div && !div_by_zero) ? abs_w(operand_1) : operand_1;
    div_divisor   = is_signed_div ? abs_w(operand_2) : operand_2;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= MDU_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush returns any busy state to IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      MDU_IDLE: begin
        if (accept && is_mul)      state_nxt = MDU_MUL;
        else if (accept && is_div) state_nxt = div_by_zero ? MDU_DIVFIX : MDU_DIV;
      end
      MDU_MUL:    state_nxt = MDU_IDLE;
      MDU_DIV: begin
        if (flush)         state_nxt = MDU_IDLE;
        else if (div_done) state_nxt = MDU_DIVFIX;
      end
      MDU_DIVFIX: state_nxt = MDU_IDLE;
      default:    state_nxt = MDU_IDLE;
    endcase
  end

  // FSM outputs. A flushed cycle never stalls, and stall is held low while
  // reset is asserted so the pipe sees a quiet unit immediately.
  always_comb begin
    mul_en    = (state == MDU_MUL);
    busy      = (state != MDU_IDLE);
    stall_req = rst_n && !flush &&
                (((state == MDU_IDLE) && op_valid && (is_mul || is_div)) ||
                 (state == MDU_DIV));
    div_start = accept && is_div;
    div_step  = (state == MDU_DIV) && !flush;
    wr_mul    = (state == MDU_MUL) && !flush;
    wr_div    = (state == MDU_DIVFIX) && !flush;
  end

  assign fsm_state = state;

  // Multiplier operand registers and recorded divide sign/zero flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_op1   <= '0;
      mul_op2   <= '0;
      mul_funct <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      if (accept && is_mul) begin
        mul_op1   <= operand_1;
        mul_op2   <= operand_2;
        mul_funct <= funct;
      end
      if (div_start) begin
        q_neg  <= is_signed_div && (operand_1[DATA_W-1] ^ operand_2[DATA_W-1]);
        r_neg  <= is_signed_div && operand_1[DATA_W-1];
        zero_q <= div_by_zero;
      end
    end
  end

  div_radix2 #(
    .ITERS(DIV_ITERS)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .step     (div_step),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quot),
    .remainder(div_rem),
    .done     (div_done)
  );

  // Architectural HI/LO: moves, multiply result, divide result with fix-up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (accept && is_mthi) begin
      hi <= operand_1;
    end else if (accept && is_mtlo) begin
      lo <= operand_1;
    end else if (wr_mul) begin
      hi <= mul_result[2*DATA_W-1:DATA_W];
      lo <= mul_result[DATA_W-1:0];
    end else if (wr_div) begin
      if (zero_q) begin
        // Quotient field still holds the untouched dividend
        hi <= div_quot;
        lo <= '1;
      end else begin
        hi <= neg_if(r_neg, div_rem);
        lo <= neg_if(q_neg, div_quot);
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: table of HI/LO operations with hand-computed
// results, latencies and stall lengths, plus sequences for moves, flush
// and asynchronous reset in the middle of a divide.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        op_valid;
  logic [5:0]  funct;
  logic [31:0] operand_1;
  logic [31:0] operand_2;
  logic        flush;
  logic        mul_en;
  logic [5:0]  mul_funct;
  logic [31:0] mul_op1;
  logic [31:0] mul_op2;
  logic [63:0] mul_result;
  logic        stall_req;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  fsm_state;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          exp_stall;
    int          exp_lat;
  } vec_t;

  vec_t vecs[12];

  muldiv_ctrl #(.DIV_ITERS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .funct     (funct),
    .operand_1 (operand_1),
    .operand_2 (operand_2),
    .flush     (flush),
    .mul_en    (mul_en),
    .mul_funct (mul_funct),
    .mul_op1   (mul_op1),
    .mul_op2   (mul_op2),
    .mul_result(mul_result),
    .stall_req (stall_req),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .fsm_state (fsm_state)
  );

  // Clock and the external combinational multiplier
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    logic [63:0] a, b;
    if (mul_funct == FUNCT_MULT) begin
      a = {{32{mul_op1[31]}}, mul_op1};
      b = {{32{mul_op2[31]}}, mul_op2};
    end else begin
      a = {32'd0, mul_op1};
      b = {32'd0, mul_op2};
    end
    mul_result = a * b;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Present one operation, hold it while stalled, then compare results
  task automatic run_vec(input int idx, input vec_t v);
    int  stall_n;
    int  lat;
    bit  done;
    stall_n = 0;
    lat     = 0;
    done    = 0;
    @(posedge clk); #1;
    op_valid  = 1'b1;
    funct     = v.funct;
    operand_1 = v.op1;
    operand_2 = v.op2;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mul_en) begin
        check($sformatf("v%0d_mul_funct", idx), 64'(mul_funct), 64'(v.funct));
        check($sformatf("v%0d_mul_op1", idx), 64'(mul_op1), 64'(v.op1));
      end
      if (stall_req) stall_n++;
      else           done = 1;
      @(posedge clk); #1;
      lat++;
    end
    op_valid = 1'b0;
    check($sformatf("v%0d_completed", idx), 64'(done), 64'd1);
    check($sformatf("v%0d_stall_cycles", idx), 64'(stall_n), 64'(v.exp_stall));
    check($sformatf("v%0d_latency", idx), 64'(lat), 64'(v.exp_lat));
    check($sformatf("v%0d_hi", idx), 64'(hi), 64'(v.exp_hi));
    check($sformatf("v%0d_lo", idx), 64'(lo), 64'(v.exp_lo));
  endtask

  // Single-cycle move, no flush
  task automatic do_move(input logic [5:0] f, input logic [31:0] val);
    @(posedge clk); #1;
    op_valid  = 1'b1;
    funct     = f;
    operand_1 = val;
    operand_2 = 32'd0;
    @(posedge clk); #1;
    op_valid  = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{FUNCT_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1,  2};
    vecs[1]  = '{FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1,  2};
    vecs[2]  = '{FUNCT_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1,  2};
    vecs[3]  = '{FUNCT_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 34};
    vecs[4]  = '{FUNCT_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33, 34};
    vecs[5]  = '{FUNCT_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1,  2};
    vecs[6]  = '{FUNCT_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 34};
    vecs[7]  = '{FUNCT_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33, 34};
    vecs[8]  = '{FUNCT_DIVU,  32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd1,        33, 34};
    vecs[9]  = '{FUNCT_DIV,   32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF, 1,  2};
    vecs[10] = '{FUNCT_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3,        33, 34};
    vecs[11] = '{FUNCT_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1,  2};

    // Reset state
    rst_n     = 1'b0;
    op_valid  = 1'b0;
    funct     = 6'd0;
    operand_1 = 32'd0;
    operand_2 = 32'd0;
    flush     = 1'b0;
    #3;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_mul_en", 64'(mul_en), 64'd0);
    check("rst_stall", 64'(stall_req), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mul_op1", 64'(mul_op1), 64'd0);
    check("rst_mul_funct", 64'(mul_funct), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // MTHI then MTLO back-to-back: no stall, each lands on its own edge
    @(posedge clk); #1;
    op_valid  = 1'b1;
    funct     = FUNCT_MTHI;
    operand_1 = 32'h1234;
    @(negedge clk);
    check("mthi_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    check("mthi_hi", 64'(hi), 64'h1234);
    funct     = FUNCT_MTLO;
    operand_1 = 32'h5678;
    @(negedge clk);
    check("mtlo_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0;
    check("mtlo_lo", 64'(lo), 64'h5678);
    check("mtlo_hi_kept", 64'(hi), 64'h1234);

    // Table of multiply/divide operations
    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Flush at cycle 10 of a divide: back to IDLE, HI/LO untouched
    do_move(FUNCT_MTHI, 32'hA5A5A5A5);
    do_move(FUNCT_MTLO, 32'hA5A5A5A5);
    @(posedge clk); #1;
    op_valid  = 1'b1;
    funct     = FUNCT_DIV;
    operand_1 = 32'd100;
    operand_2 = 32'd7;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_busy_before", 64'(busy), 64'd1);
    check("flush_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    flush    = 1'b0;
    op_valid = 1'b0;
    check("flush_busy_after", 64'(busy), 64'd0);
    check("flush_state_idle", 64'(fsm_state), 64'(MDU_IDLE));
    check("flush_hi", 64'(hi), 64'hA5A5A5A5);
    check("flush_lo", 64'(lo), 64'hA5A5A5A5);
    repeat (40) @(posedge clk);
    #1;
    check("flush_hi_late", 64'(hi), 64'hA5A5A5A5);
    check("flush_lo_late", 64'(lo), 64'hA5A5A5A5);

    // Flush coincident with an op in IDLE: neither a divide nor a move is taken
    op_valid  = 1'b1;
    flush     = 1'b1;
    funct     = FUNCT_DIVU;
    operand_1 = 32'd9;
    operand_2 = 32'd3;
    @(negedge clk);
    check("idle_flush_div_stall", 64'(stall_req), 64'd0);
    @(posedge clk); #1;
    check("idle_flush_div_busy", 64'(busy), 64'd0);
    funct     = FUNCT_MTHI;
    operand_1 = 32'hDEADBEEF;
    @(posedge clk); #1;
    check("idle_flush_mthi_hi", 64'(hi), 64'hA5A5A5A5);
    op_valid = 1'b0;
    flush    = 1'b0;

    // Asynchronous reset at cycle 10 of a divide: outputs clear without an edge
    @(posedge clk); #1;
    op_valid  = 1'b1;
    funct     = FUNCT_DIV;
    operand_1 = 32'hFFFFFFF9;
    operand_2 = 32'd2;
    repeat (10) @(posedge clk);
    #2;
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_mul_op1", 64'(mul_op1), 64'd0);
    check("arst_mul_op2", 64'(mul_op2), 64'd0);
    check("arst_mul_funct", 64'(mul_funct), 64'd0);
    check("arst_mul_en", 64'(mul_en), 64'd0);
    check("arst_stall", 64'(stall_req), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    op_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", 64'(fsm_state), 64'(MDU_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
